// File: rtl/immediate_decode_stage.sv
// Immediate generator for RV32/RV64 decode, followed by a DEPTH-entry in-order
// valid/ready FIFO. Optional macro IMM_TYPE_CHECK_EN flags type 111 and counts it.
module immediate_decode_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [2:0]                   in_type,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_imm,
  output logic [2:0]                   out_type,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_err,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] i, input logic [2:0] t);
    logic signed [31:0] v;
    logic [XLEN-1:0]    r;
    v = '0;
    r = '0;
    case (t)
      3'b000: begin v = {{20{i[31]}}, i[31:20]};                                   r = XLEN'(v); end
      3'b001: begin v = {{20{i[31]}}, i[31:25], i[11:7]};                          r = XLEN'(v); end
      3'b010: begin v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};       r = XLEN'(v); end
      3'b011: begin v = {i[31:12], 12'b0};                                         r = XLEN'(v); end
      3'b100: begin v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};     r = XLEN'(v); end
      3'b101: r = XLEN'(i[19:15]);
      3'b110: r = (XLEN == 64) ? XLEN'(i[25:20]) : XLEN'(i[24:20]);
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0]  mem_imm  [DEPTH];
  logic [2:0]       mem_type [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic             mem_err  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop, err_p0;
  logic             unused_opcode;

  assign unused_opcode = ^in_instr[6:0];

`ifdef IMM_TYPE_CHECK_EN
  assign err_p0 = (in_type == 3'b111);
`else
  assign err_p0 = 1'b0;
`endif

  assign in_ready  = (occupancy < OW'(DEPTH)) && !flush;
  assign out_valid = (occupancy != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  // Stage p0 -> storage: computed immediate is written at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_imm[k]  <= '0;
        mem_type[k] <= '0;
        mem_tag[k]  <= '0;
        mem_err[k]  <= 1'b0;
      end
    end else if (push) begin
      mem_imm[wr_ptr]  <= gen_imm(in_instr, in_type);
      mem_type[wr_ptr] <= in_type;
      mem_tag[wr_ptr]  <= in_tag;
      mem_err[wr_ptr]  <= err_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + OW'(push) - OW'(pop);
    end
  end

  // Head of FIFO drives the outputs; storage is zero after reset so outputs are too
  assign out_imm  = mem_imm[rd_ptr];
  assign out_type = mem_type[rd_ptr];
  assign out_tag  = mem_tag[rd_ptr];
  assign out_err  = mem_err[rd_ptr];

`ifdef IMM_TYPE_CHECK_EN
  logic [7:0] illegal_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_cnt <= '0;
    else if (push && err_p0 && illegal_cnt != 8'hFF)
      illegal_cnt <= illegal_cnt + 8'd1;
  end
`endif

endmodule
